// File: rtl/bwt_pkg.sv
// rtl/bwt_pkg.sv - shared types and helpers for the inverse BWT decoder
package bwt_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RANK,
        WALK,
        DONE
    } ibwt_state_e;

    // Index width that stays at least 1 bit even for degenerate lengths
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ibwt_decoder_if.sv
// rtl/ibwt_decoder_if.sv - request/result bundle between a client and the decoder
interface ibwt_decoder_if import bwt_pkg::*; #(
    parameter int STRING_LEN = 8
) ();
    localparam int IDX_W = idx_w(STRING_LEN);

    logic                     start;
    byte_t [STRING_LEN-1:0]   data_in;
    logic  [IDX_W:0]          primary_idx;
    byte_t [STRING_LEN-1:0]   data_out;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, data_in, primary_idx,
        input  data_out, busy, done, err
    );

    modport slave (
        input  start, data_in, primary_idx,
        output data_out, busy, done, err
    );
endinterface

// File: rtl/lf_rank.sv
// rtl/lf_rank.sv - LF-mapping rank of one L-column position
module lf_rank import bwt_pkg::*; #(
    parameter int STRING_LEN = 8,
    parameter int IDX_W      = idx_w(STRING_LEN)
) (
    input  byte_t [STRING_LEN-1:0] l,
    input  logic  [IDX_W-1:0]      rk,
    output logic  [IDX_W-1:0]      lf
);
    byte_t                 sym;
    logic [STRING_LEN-1:0] term;

    assign sym = l[rk];

    // Each term marks a symbol sorting before l[rk]; equal symbols break ties by position
    always_comb begin
        term = '0;
        for (int j = 0; j < STRING_LEN; j++) begin
            term[j] = (l[j] < sym) || ((l[j] == sym) && (IDX_W'(j) < rk));
        end
    end

    // Popcount of the terms; at most STRING_LEN-1 are set, so IDX_W bits suffice
    always_comb begin
        lf = '0;
        for (int j = 0; j < STRING_LEN; j++) begin
            lf = lf + IDX_W'(term[j]);
        end
    end
endmodule

// File: rtl/ibwt_decoder.sv
// rtl/ibwt_decoder.sv - inverse Burrows-Wheeler transform via LF-mapping walk
module ibwt_decoder import bwt_pkg::*; #(
    parameter int STRING_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    ibwt_decoder_if.slave    bus
);
    localparam int IDX_W = idx_w(STRING_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STRING_LEN - 1);

    ibwt_state_e             state;
    ibwt_state_e             next_state;
    byte_t [STRING_LEN-1:0]  l_reg;
    logic  [IDX_W-1:0]       lf_mem [STRING_LEN];
    logic  [IDX_W-1:0]       lf_val;
    logic  [IDX_W-1:0]       p;
    logic  [IDX_W-1:0]       k;
    logic  [IDX_W-1:0]       rk;
    logic                    accept;
    logic                    bad_idx;

    lf_rank #(
        .STRING_LEN (STRING_LEN),
        .IDX_W      (IDX_W)
    ) u_lf_rank (
        .l  (l_reg),
        .rk (rk),
        .lf (lf_val)
    );

    // State register; reset aborts any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a bad row index never leaves IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && !bad_idx) next_state = RANK;
            RANK: if (rk == LAST)         next_state = WALK;
            WALK: if (k == '0)            next_state = DONE;
            DONE:                         next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    // Decoded control: start is only honoured in IDLE
    always_comb begin
        accept   = (state == IDLE) && bus.start;
        bad_idx  = bus.primary_idx >= (IDX_W+1)'(STRING_LEN);
        bus.busy = (state != IDLE);
    end

    // Datapath: latch job, fill lf table, then walk it backwards into data_out
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            rk           <= '0;
            k            <= '0;
            p            <= '0;
        end else begin
            bus.done <= (state == DONE) || (accept && bad_idx);
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_reg   <= bus.data_in;
                        p       <= bus.primary_idx[IDX_W-1:0];
                        bus.err <= bad_idx;
                        rk      <= '0;
                    end
                end
                RANK: begin
                    lf_mem[rk] <= lf_val;
                    rk         <= rk + IDX_W'(1);
                    k          <= LAST;
                end
                WALK: begin
                    bus.data_out[k] <= l_reg[p];
                    p               <= lf_mem[p];
                    k               <= k - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
